// File: rtl/agregador_medidas_n_if.sv
// Bus bundle for agregador_medidas_n: start/strobe/measurement inputs and the
// registered result outputs of one measure/classify round.
//   master: drives iniciar, medidas, validos; observes the results
//   slave : the aggregator itself
interface agregador_medidas_n_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned W   = 12
);
    logic             iniciar;
    logic [NCH*W-1:0] medidas;
    logic [NCH-1:0]   validos;
    logic [W-1:0]     media;
    logic [1:0]       classe;
    logic             descartar;
    logic [NCH-1:0]   canais_ok;
    logic             pronto;
    logic             ocupado;
    logic [3:0]       db_estado;

    modport master (
        output iniciar, medidas, validos,
        input  media, classe, descartar, canais_ok, pronto, ocupado, db_estado
    );

    modport slave (
        input  iniciar, medidas, validos,
        output media, classe, descartar, canais_ok, pronto, ocupado, db_estado
    );
endinterface

// File: rtl/agregador_medidas_n.sv
// agregador_medidas_n: collects one distance per channel from NCH sensors
// (with a timeout), averages the captured channels with a sequential
// restoring divider, checks their spread and classifies the mean.
//
// Ports:
//   clock   system clock
//   zera_n  synchronous reset, active low
//   bus     agregador_medidas_n_if.slave
//           in : iniciar, medidas[NCH*W] (ch i at [i*W +: W]), validos[NCH]
//           out: media[W], classe[2], descartar, canais_ok[NCH], pronto,
//                ocupado, db_estado[4]
//
// Optional feature macro: DESCARTE_EXTREMOS_EN
//   When defined, an AJUSTA cycle drops the min and max sample from the
//   average whenever at least 3 channels were captured.
module agregador_medidas_n #(
    parameter int unsigned NCH          = 3,
    parameter int unsigned W            = 12,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned MIN_CANAIS   = 2,
    parameter int unsigned TOL          = 20,
    parameter int unsigned LIMIAR_BAIXO = 100,
    parameter int unsigned LIMIAR_ALTO  = 300
) (
    input  logic                  clock,
    input  logic                  zera_n,
    agregador_medidas_n_if.slave  bus
);
    localparam int unsigned CW    = $clog2(NCH + 1);
    localparam int unsigned CW1   = CW + 1;
    localparam int unsigned SW    = W + CW;
    localparam int unsigned IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CTMAX = (TIMEOUT > W) ? TIMEOUT : W;
    localparam int unsigned CTW   = (CTMAX > 1) ? $clog2(CTMAX) : 1;

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        ESPERA     = 4'd1,
        ACUMULA    = 4'd2,
        AJUSTA     = 4'd3,
        DIVIDE     = 4'd4,
        CLASSIFICA = 4'd5,
        FIM        = 4'd6
    } estado_t;

    estado_t          state_q, state_d;
    logic [W-1:0]     cap_q [NCH];
    logic [W-1:0]     cap_d [NCH];
    logic [NCH-1:0]   capv_q, capv_d;
    logic [CTW-1:0]   ctr_q, ctr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    dvs_q, dvs_d;
    logic [W-1:0]     min_q, min_d;
    logic [W-1:0]     max_q, max_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;

    logic [W-1:0]     media_q, media_d;
    logic [1:0]       classe_q, classe_d;
    logic             descartar_q, descartar_d;
    logic [NCH-1:0]   canais_ok_q, canais_ok_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;
    logic [3:0]       db_estado_q, db_estado_d;

    logic [CW1-1:0]   trial_c;
    logic             qbit_c;
    logic [W-1:0]     media_c;
    logic             desc_c;
    logic [W-1:0]     amostra_c;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!zera_n) begin
            state_q     <= OCIOSO;
            cap_q       <= '{default: '0};
            capv_q      <= '0;
            ctr_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            dvs_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            media_q     <= '0;
            classe_q    <= 2'b00;
            descartar_q <= 1'b0;
            canais_ok_q <= '0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            db_estado_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            capv_q      <= capv_d;
            ctr_q       <= ctr_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            dvs_q       <= dvs_d;
            min_q       <= min_d;
            max_q       <= max_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            media_q     <= media_d;
            classe_q    <= classe_d;
            descartar_q <= descartar_d;
            canais_ok_q <= canais_ok_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
            db_estado_q <= db_estado_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        capv_d      = capv_q;
        ctr_d       = ctr_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        dvs_d       = dvs_q;
        min_d       = min_q;
        max_d       = max_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        media_d     = media_q;
        classe_d    = classe_q;
        descartar_d = descartar_q;
        canais_ok_d = canais_ok_q;
        pronto_d    = 1'b0;
        trial_c     = '0;
        qbit_c      = 1'b0;
        media_c     = '0;
        desc_c      = 1'b0;
        amostra_c   = cap_q[idx_q];

        case (state_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    state_d = ESPERA;
                    cap_d   = '{default: '0};
                    capv_d  = '0;
                    ctr_d   = '0;
                end
            end

            ESPERA: begin
                // First strobe per channel wins; later strobes are ignored
                for (int i = 0; i < NCH; i++) begin
                    if (bus.validos[i] && !capv_q[i]) begin
                        capv_d[i] = 1'b1;
                        cap_d[i]  = bus.medidas[i*W +: W];
                    end
                end
                ctr_d = ctr_q + CTW'(1);
                if ((&capv_d) || (ctr_q == CTW'(TIMEOUT - 1))) begin
                    state_d = ACUMULA;
                    idx_d   = '0;
                    sum_d   = '0;
                    cnt_d   = '0;
                    min_d   = '0;
                    max_d   = '0;
                end
            end

            ACUMULA: begin
                if (capv_q[idx_q]) begin
                    sum_d = sum_q + SW'(amostra_c);
                    cnt_d = cnt_q + CW'(1);
                    // The first valid sample seeds both extremes
                    if ((cnt_q == '0) || (amostra_c < min_q)) min_d = amostra_c;
                    if ((cnt_q == '0) || (amostra_c > max_q)) max_d = amostra_c;
                end
                dvs_d = cnt_d;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NCH - 1)) begin
`ifdef DESCARTE_EXTREMOS_EN
                    state_d = AJUSTA;
`else
                    state_d = DIVIDE;
`endif
                end
            end

`ifdef DESCARTE_EXTREMOS_EN
            AJUSTA: begin
                // Only the divisor path is trimmed; cnt/min/max stay full-set
                if (32'(cnt_q) >= 32'd3) begin
                    sum_d = sum_q - SW'(min_q) - SW'(max_q);
                    dvs_d = cnt_q - CW'(2);
                end
                state_d = DIVIDE;
            end
`endif

            DIVIDE: begin
                // One restoring step per cycle; quo_q shifts dividend out, quotient in
                trial_c = {rem_q, quo_q[W-1]};
                if (trial_c >= CW1'(dvs_q)) begin
                    rem_d  = CW'(trial_c - CW1'(dvs_q));
                    qbit_c = 1'b1;
                end else begin
                    rem_d  = CW'(trial_c);
                end
                quo_d = W'({quo_q, qbit_c});
                ctr_d = ctr_q + CTW'(1);
                if (ctr_q == CTW'(W - 1)) begin
                    state_d = CLASSIFICA;
                end
            end

            CLASSIFICA: begin
                media_c = (dvs_q == '0) ? '0 : quo_q;
                desc_c  = (32'(cnt_q) < MIN_CANAIS) ||
                          ((cnt_q != '0) && ((max_q - min_q) > W'(TOL)));
                media_d     = media_c;
                descartar_d = desc_c;
                canais_ok_d = capv_q;
                if (desc_c)                          classe_d = 2'b11;
                else if (media_c < W'(LIMIAR_BAIXO)) classe_d = 2'b01;
                else if (media_c > W'(LIMIAR_ALTO))  classe_d = 2'b10;
                else                                 classe_d = 2'b00;
                pronto_d = 1'b1;
                state_d  = FIM;
            end

            FIM: begin
                state_d = OCIOSO;
            end

            default: begin
                state_d = OCIOSO;
            end
        endcase

        // Divider preload: the quotient fits in W bits, so the bits of the sum
        // above W seed the remainder and only W steps are needed
        if ((state_d == DIVIDE) && (state_q != DIVIDE)) begin
            rem_d = CW'(sum_d >> W);
            quo_d = sum_d[W-1:0];
            ctr_d = '0;
        end

        ocupado_d   = (state_d != OCIOSO);
        db_estado_d = 4'(state_d);
    end

    assign bus.media     = media_q;
    assign bus.classe    = classe_q;
    assign bus.descartar = descartar_q;
    assign bus.canais_ok = canais_ok_q;
    assign bus.pronto    = pronto_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.db_estado = db_estado_q;
endmodule

// File: tb/tb_agregador_medidas_n.sv
// Self-checking bench for agregador_medidas_n: directed rounds, timeout,
// first-capture-wins, busy start, mid-divide reset and randomised rounds
// against a behavioural reference model.
module tb_agregador_medidas_n;
    localparam int unsigned NCH          = 3;
    localparam int unsigned W            = 12;
    localparam int unsigned TIMEOUT      = 1000;
    localparam int unsigned MIN_CANAIS   = 2;
    localparam int unsigned TOL          = 20;
    localparam int unsigned LIMIAR_BAIXO = 100;
    localparam int unsigned LIMIAR_ALTO  = 300;
    localparam int          RUN_BUDGET   = TIMEOUT + NCH + W + 20;

    logic clk = 1'b0;
    logic zera_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    agregador_medidas_n_if #(.NCH(NCH), .W(W)) bus ();

    agregador_medidas_n #(
        .NCH(NCH), .W(W), .TIMEOUT(TIMEOUT), .MIN_CANAIS(MIN_CANAIS), .TOL(TOL),
        .LIMIAR_BAIXO(LIMIAR_BAIXO), .LIMIAR_ALTO(LIMIAR_ALTO)
    ) dut (
        .clock  (clk),
        .zera_n (zera_n),
        .bus    (bus)
    );

    // Reference: average/spread/class computed directly from the captured set
    function automatic void model(input logic [NCH*W-1:0] vals, input logic [NCH-1:0] mask,
                                  output logic [W-1:0] e_media, output logic [1:0] e_classe,
                                  output logic e_desc);
        int s, c, mn, mx, v, ds, dc, m;
        s = 0; c = 0; mn = 0; mx = 0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) begin
                v = int'(vals[i*W +: W]);
                s += v;
                if (c == 0) begin mn = v; mx = v; end
                else begin
                    if (v < mn) mn = v;
                    if (v > mx) mx = v;
                end
                c++;
            end
        end
        ds = s; dc = c;
`ifdef DESCARTE_EXTREMOS_EN
        if (c >= 3) begin ds = s - mn - mx; dc = c - 2; end
`endif
        m = (dc == 0) ? 0 : ds / dc;
        e_media = W'(m);
        e_desc  = (c < int'(MIN_CANAIS)) || (c > 0 && (mx - mn) > int'(TOL));
        if (e_desc)                        e_classe = 2'b11;
        else if (m < int'(LIMIAR_BAIXO))   e_classe = 2'b01;
        else if (m > int'(LIMIAR_ALTO))    e_classe = 2'b10;
        else                               e_classe = 2'b00;
    endfunction

    // Starts a round, strobes each masked channel at a random cycle (plus junk
    // re-strobes afterwards), and waits for pronto within a cycle budget
    task automatic run_round(input logic [NCH*W-1:0] vals, input logic [NCH-1:0] mask,
                             input int maxd, output int lat, output bit got);
        int d [NCH];
        logic [NCH-1:0]   v_s;
        logic [NCH*W-1:0] m_s;
        for (int i = 0; i < NCH; i++) d[i] = int'($urandom_range(maxd, 1));
        @(negedge clk);
        bus.iniciar = 1'b1;
        bus.validos = NCH'($urandom);
        bus.medidas = ~vals;
        lat = 0;
        got = 1'b0;
        while (!got && lat < RUN_BUDGET) begin
            @(negedge clk);
            lat++;
            if (bus.pronto) got = 1'b1;
            bus.iniciar = 1'b0;
            v_s = '0;
            m_s = '0;
            for (int i = 0; i < NCH; i++) begin
                if (mask[i]) begin
                    if (lat == d[i]) begin
                        v_s[i] = 1'b1;
                        m_s[i*W +: W] = vals[i*W +: W];
                    end else if (lat > d[i] && $urandom_range(1, 0) == 1) begin
                        v_s[i] = 1'b1;
                        m_s[i*W +: W] = W'($urandom);
                    end
                end
            end
            bus.validos = v_s;
            bus.medidas = m_s;
        end
        bus.validos = '0;
    endtask

    task automatic wait_pronto(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < RUN_BUDGET) begin
            @(negedge clk);
            lat++;
            bus.validos = '0;
            if (bus.pronto) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        zera_n = 1'b0;
        repeat (3) @(negedge clk);
        zera_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.media !== '0)     begin failures++; $display("FAIL reset_media got=%0d exp=0", bus.media); end
        checks++; if (bus.classe !== 2'b00) begin failures++; $display("FAIL reset_classe got=%b exp=00", bus.classe); end
        checks++; if (bus.descartar !== 1'b0) begin failures++; $display("FAIL reset_descartar got=%b exp=0", bus.descartar); end
        checks++; if (bus.canais_ok !== '0) begin failures++; $display("FAIL reset_canais_ok got=%b exp=0", bus.canais_ok); end
        checks++; if (bus.pronto !== 1'b0)  begin failures++; $display("FAIL reset_pronto got=%b exp=0", bus.pronto); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado got=%b exp=0", bus.ocupado); end
        checks++; if (bus.db_estado !== 4'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", bus.db_estado); end
    endtask

    task automatic test_directed();
        int dv [4][3];
        int dm [4];
        logic [1:0] dc [4];
        logic dd [4];
        logic [NCH*W-1:0] vals;
        int lat;
        bit got;
        dv = '{'{200, 210, 205}, '{50, 52, 54}, '{400, 405, 410}, '{200, 250, 205}};
        dm = '{205, 52, 405, 218};
`ifdef DESCARTE_EXTREMOS_EN
        dm[3] = 205;
`endif
        dc = '{2'b00, 2'b01, 2'b10, 2'b11};
        dd = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NCH; i++) vals[i*W +: W] = W'(dv[k][i]);
            run_round(vals, '1, 4, lat, got);
            checks++; if (!got) begin failures++; $display("FAIL dir%0d_pronto no pronto within %0d cycles", k, RUN_BUDGET); end
            checks++; if (bus.media !== W'(dm[k])) begin failures++; $display("FAIL dir%0d_media got=%0d exp=%0d", k, bus.media, dm[k]); end
            checks++; if (bus.classe !== dc[k]) begin failures++; $display("FAIL dir%0d_classe got=%b exp=%b", k, bus.classe, dc[k]); end
            checks++; if (bus.descartar !== dd[k]) begin failures++; $display("FAIL dir%0d_descartar got=%b exp=%b", k, bus.descartar, dd[k]); end
            checks++; if (bus.canais_ok !== 3'b111) begin failures++; $display("FAIL dir%0d_canais_ok got=%b exp=111", k, bus.canais_ok); end
            @(negedge clk);
            checks++; if (bus.pronto !== 1'b0) begin failures++; $display("FAIL dir%0d_pronto_pulse got=%b exp=0", k, bus.pronto); end
        end
    endtask

    task automatic test_timeout();
        logic [NCH*W-1:0] vals;
        int lat;
        bit got;
        vals = '0;
        vals[0 +: W] = W'(200);
        run_round(vals, 3'b001, 3, lat, got);
        checks++; if (!got || lat != int'(TIMEOUT + NCH + W + 2)) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, TIMEOUT + NCH + W + 2); end
        checks++; if (bus.canais_ok !== 3'b001) begin failures++; $display("FAIL tmo_canais_ok got=%b exp=001", bus.canais_ok); end
        checks++; if (bus.descartar !== 1'b1) begin failures++; $display("FAIL tmo_descartar got=%b exp=1", bus.descartar); end
        checks++; if (bus.media !== W'(200)) begin failures++; $display("FAIL tmo_media got=%0d exp=200", bus.media); end
        checks++; if (bus.classe !== 2'b11) begin failures++; $display("FAIL tmo_classe got=%b exp=11", bus.classe); end
        run_round(vals, 3'b000, 3, lat, got);
        checks++; if (!got) begin failures++; $display("FAIL none_pronto no pronto within %0d cycles", RUN_BUDGET); end
        checks++; if (bus.media !== '0) begin failures++; $display("FAIL none_media got=%0d exp=0", bus.media); end
        checks++; if (bus.classe !== 2'b11) begin failures++; $display("FAIL none_classe got=%b exp=11", bus.classe); end
        checks++; if (bus.canais_ok !== 3'b000) begin failures++; $display("FAIL none_canais_ok got=%b exp=000", bus.canais_ok); end
    endtask

    task automatic test_first_wins();
        int lat;
        bit got;
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(negedge clk);
        bus.iniciar = 1'b0;
        bus.validos = 3'b010;
        bus.medidas = '0;
        bus.medidas[W +: W] = W'(300);
        @(negedge clk);
        bus.validos = 3'b010;
        bus.medidas[W +: W] = W'(100);
        @(negedge clk);
        bus.validos = 3'b101;
        bus.medidas[0 +: W]   = W'(290);
        bus.medidas[2*W +: W] = W'(310);
        wait_pronto(lat, got);
        // 290/300/310: spread exactly TOL and mean exactly LIMIAR_ALTO
        checks++; if (!got) begin failures++; $display("FAIL fw_pronto no pronto within %0d cycles", RUN_BUDGET); end
        checks++; if (bus.media !== W'(300)) begin failures++; $display("FAIL fw_media got=%0d exp=300", bus.media); end
        checks++; if (bus.classe !== 2'b00) begin failures++; $display("FAIL fw_classe got=%b exp=00", bus.classe); end
        checks++; if (bus.descartar !== 1'b0) begin failures++; $display("FAIL fw_descartar got=%b exp=0", bus.descartar); end
    endtask

    task automatic test_busy_ignore();
        int prontos;
        int n;
        bit seen_busy;
        bit busy_after;
        prontos = 0; n = 0; seen_busy = 1'b0; busy_after = 1'b0;
        @(negedge clk);
        bus.iniciar = 1'b1;
        bus.validos = '0;
        @(negedge clk);
        bus.iniciar = 1'b0;
        bus.validos = '1;
        bus.medidas = {W'(110), W'(120), W'(130)};
        while (prontos == 0 && n < RUN_BUDGET) begin
            @(negedge clk);
            n++;
            bus.validos = '0;
            if (bus.pronto) prontos++;
            if (bus.ocupado) seen_busy = 1'b1;
            bus.iniciar = bus.ocupado;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.iniciar = 1'b0;
            if (bus.pronto) prontos++;
            if (bus.ocupado) busy_after = 1'b1;
        end
        checks++; if (prontos != 1) begin failures++; $display("FAIL busy_prontos got=%0d exp=1", prontos); end
        checks++; if (!seen_busy) begin failures++; $display("FAIL busy_ocupado got=0 exp=1"); end
        checks++; if (busy_after) begin failures++; $display("FAIL busy_second_round got=1 exp=0"); end
        checks++; if (bus.media !== W'(120)) begin failures++; $display("FAIL busy_media got=%0d exp=120", bus.media); end
    endtask

    task automatic test_reset_mid_divide();
        int n;
        int lat;
        bit got;
        logic [NCH*W-1:0] vals;
        logic [W-1:0] e_m;
        logic [1:0] e_c;
        logic e_d;
        n = 0;
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(negedge clk);
        bus.iniciar = 1'b0;
        bus.validos = '1;
        bus.medidas = {W'(700), W'(705), W'(710)};
        while (bus.db_estado !== 4'd4 && n < 100) begin
            @(negedge clk);
            bus.validos = '0;
            n++;
        end
        checks++; if (bus.db_estado !== 4'd4) begin failures++; $display("FAIL mid_reach_divide got=%0d exp=4", bus.db_estado); end
        zera_n = 1'b0;
        @(negedge clk);
        zera_n = 1'b1;
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL mid_ocupado got=%b exp=0", bus.ocupado); end
        checks++; if (bus.media !== '0) begin failures++; $display("FAIL mid_media got=%0d exp=0", bus.media); end
        checks++; if (bus.classe !== 2'b00) begin failures++; $display("FAIL mid_classe got=%b exp=00", bus.classe); end
        checks++; if (bus.canais_ok !== '0) begin failures++; $display("FAIL mid_canais_ok got=%b exp=0", bus.canais_ok); end
        checks++; if (bus.db_estado !== 4'd0) begin failures++; $display("FAIL mid_estado got=%0d exp=0", bus.db_estado); end
        vals = {W'(330), W'(340), W'(335)};
        model(vals, '1, e_m, e_c, e_d);
        run_round(vals, '1, 5, lat, got);
        checks++; if (!got) begin failures++; $display("FAIL mid_after_pronto no pronto within %0d cycles", RUN_BUDGET); end
        checks++; if (bus.media !== e_m) begin failures++; $display("FAIL mid_after_media got=%0d exp=%0d", bus.media, e_m); end
        checks++; if (bus.classe !== e_c) begin failures++; $display("FAIL mid_after_classe got=%b exp=%b", bus.classe, e_c); end
    endtask

    task automatic test_random();
        logic [NCH*W-1:0] vals;
        logic [NCH-1:0] mask;
        logic [W-1:0] e_m;
        logic [1:0] e_c;
        logic e_d;
        int base, spread, v, lat;
        bit got;
        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(2, 0))
                0:       base = int'($urandom_range(150, 0));
                1:       base = int'($urandom_range(350, 80));
                default: base = int'($urandom_range(4000, 250));
            endcase
            spread = ($urandom_range(1, 0) == 1) ? 20 : 60;
            for (int i = 0; i < NCH; i++) begin
                v = base + int'($urandom_range(spread, 0));
                if (v > 4095) v = 4095;
                vals[i*W +: W] = W'(v);
            end
            mask = ($urandom_range(2, 0) != 0) ? '1 : NCH'($urandom);
            model(vals, mask, e_m, e_c, e_d);
            run_round(vals, mask, 8, lat, got);
            checks++; if (!got) begin failures++; $display("FAIL rnd%0d_pronto no pronto within %0d cycles", r, RUN_BUDGET); end
            checks++; if (bus.media !== e_m) begin failures++; $display("FAIL rnd%0d_media got=%0d exp=%0d", r, bus.media, e_m); end
            checks++; if (bus.classe !== e_c) begin failures++; $display("FAIL rnd%0d_classe got=%b exp=%b", r, bus.classe, e_c); end
            checks++; if (bus.descartar !== e_d) begin failures++; $display("FAIL rnd%0d_descartar got=%b exp=%b", r, bus.descartar, e_d); end
            checks++; if (bus.canais_ok !== mask) begin failures++; $display("FAIL rnd%0d_canais_ok got=%b exp=%b", r, bus.canais_ok, mask); end
        end
    endtask

    initial begin
        zera_n      = 1'b0;
        bus.iniciar = 1'b0;
        bus.validos = '0;
        bus.medidas = '0;
        test_reset();
        test_directed();
        test_timeout();
        test_first_wins();
        test_busy_ignore();
        test_reset_mid_divide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
